// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Multicycle sequencer for the ARM-subset core: fetches into IR, evaluates the
// condition field against the held NZCV flags and steps the datapath through
// FETCH / DECODE / EXEC_DP / MEM_ADDR / MEM_RD / MEM_WR / WB / BRANCH.
// Memory requests are held until acked; an ack that does not arrive within
// TIMEOUT cycles raises a sticky bus_error and parks the sequencer in HALT.
// Optional feature macro: CTRL_PERF_CNT_EN adds retired_cnt / cycle_cnt.
module arm_multicycle_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic       I,
  input  logic [3:0] OpCode,
  input  logic       S,
  input  logic       P,
  input  logic       U,
  input  logic       W,
  input  logic       L1,
  input  logic       L2,
  input  logic [3:0] Rd,
  input  logic [3:0] alu_nzcv,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_write,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_imm,
  output logic       reg_write,
  output logic       result_src,
  output logic       base_write,
  output logic       link_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] flags,
  output logic       illegal_instr,
  output logic       bus_error
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_DP  = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_WB       = 4'd6,
    ST_BRANCH   = 4'd7,
    ST_HALT     = 4'd8
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      flags_q, flags_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            bus_error_q, bus_error_d;
  logic            cond_pass;
  logic            to_hit;

  // Standard ARM condition evaluation; flags are {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = ~z;
      4'b0010: eval_cond = cy;
      4'b0011: eval_cond = ~cy;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = ~n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = ~v;
      4'b1000: eval_cond = cy & ~z;
      4'b1001: eval_cond = ~cy | z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = ~z & (n == v);
      4'b1101: eval_cond = z | (n != v);
      4'b1110: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  assign cond_pass = eval_cond(Cond, flags_q);
  assign to_hit    = (wait_cnt_q == TO_LAST);

  // Next-state, flag update and datapath strobes for the current state.
  // Strobes are decoded from the state so that ir_write coincides with
  // imem_ack; while rst is high every strobe is forced low.
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    wait_cnt_d    = '0;
    bus_error_d   = bus_error_q;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    alu_ctrl      = 4'b0000;
    alu_src_imm   = 1'b0;
    reg_write     = 1'b0;
    result_src    = 1'b0;
    base_write    = 1'b0;
    link_write    = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    illegal_instr = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (to_hit) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_DECODE: begin
        if (!cond_pass || Op == 2'b11) begin
          // Skipped or illegal instruction: just step the PC.
          pc_write      = 1'b1;
          pc_src        = 2'b00;
          illegal_instr = (Op == 2'b11);
          state_d       = ST_FETCH;
        end else begin
          case (Op)
            2'b00:   state_d = ST_EXEC_DP;
            2'b01:   state_d = ST_MEM_ADDR;
            default: state_d = ST_BRANCH;
          endcase
        end
      end

      ST_EXEC_DP: begin
        alu_ctrl    = OpCode;
        alu_src_imm = I;
        if (OpCode[3:2] == 2'b10) begin
          // TST/TEQ/CMP/CMN: compare only, always update flags.
          reg_write = 1'b0;
          flags_d   = alu_nzcv;
        end else begin
          reg_write = 1'b1;
          if (S) flags_d = alu_nzcv;
        end
        pc_write = 1'b1;
        pc_src   = (Rd == 4'hF) ? 2'b10 : 2'b00;
        state_d  = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_ctrl    = U ? ALU_ADD : ALU_SUB;
        alu_src_imm = ~I;
        base_write  = W | ~P;
        state_d     = L1 ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD, ST_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = ~L1;
        if (dmem_ack) begin
          if (state_q == ST_MEM_RD) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            pc_src   = 2'b00;
            state_d  = ST_FETCH;
          end
        end else if (to_hit) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        pc_write   = 1'b1;
        pc_src     = 2'b00;
        state_d    = ST_FETCH;
      end

      ST_BRANCH: begin
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        link_write = L2;
        state_d    = ST_FETCH;
      end

      default: begin
        // HALT: wait for reset with all strobes idle.
        state_d = ST_HALT;
      end
    endcase

    if (rst) begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      alu_ctrl      = 4'b0000;
      alu_src_imm   = 1'b0;
      reg_write     = 1'b0;
      result_src    = 1'b0;
      base_write    = 1'b0;
      link_write    = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      illegal_instr = 1'b0;
    end
  end

  assign flags     = flags_q;
  assign bus_error = bus_error_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        retire;

  // An instruction retires on the cycle that returns a passed DP/MEM/BRANCH to FETCH.
  assign retire = (state_q == ST_EXEC_DP) || (state_q == ST_BRANCH) ||
                  (state_q == ST_WB) || (state_q == ST_MEM_WR && dmem_ack);

  // Performance counters, free-running and wrapping.
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
    cycle_cnt_d   = cycle_cnt_q + {31'd0, (state_q != ST_HALT)};
  end

  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
`endif

  // State, flags, wait counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      flags_q       <= 4'b0000;
      wait_cnt_q    <= '0;
      bus_error_q   <= 1'b0;
`ifdef CTRL_PERF_CNT_EN
      retired_cnt_q <= 32'd0;
      cycle_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_error_q   <= bus_error_d;
`ifdef CTRL_PERF_CNT_EN
      retired_cnt_q <= retired_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Testbench for arm_multicycle_ctrl: a per-cycle vector table covering DP,
// compare, branch, condition fail, illegal and store, followed by directed
// sequences for a delayed load, fetch timeout and reset during a data access.
module tb_arm_multicycle_ctrl;

  localparam int TIMEOUT = 200;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic       i;
    logic [3:0] opc;
    logic       s, p, u, w, l1, l2;
    logic [3:0] rd;
    logic [3:0] nzcv;
    logic       iack, dack;
  } in_t;

  typedef struct packed {
    logic       ireq, irw, dreq, dwe;
    logic [3:0] alu;
    logic       imm, rw, rsrc, bw, lw, pcw;
    logic [1:0] pcs;
    logic [3:0] flg;
    logic       ill, be;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] Cond = 0, OpCode = 0, Rd = 0, alu_nzcv = 0;
  logic [1:0] Op = 0;
  logic I = 0, S = 0, P = 0, U = 0, W = 0, L1 = 0, L2 = 0, imem_ack = 0, dmem_ack = 0;
  logic imem_req, ir_write, dmem_req, dmem_we, alu_src_imm, reg_write, result_src;
  logic base_write, link_write, pc_write, illegal_instr, bus_error;
  logic [3:0] alu_ctrl, flags;
  logic [1:0] pc_src;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  arm_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .I(I), .OpCode(OpCode), .S(S),
    .P(P), .U(U), .W(W), .L1(L1), .L2(L2), .Rd(Rd), .alu_nzcv(alu_nzcv),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .result_src(result_src), .base_write(base_write),
    .link_write(link_write), .pc_write(pc_write), .pc_src(pc_src), .flags(flags),
    .illegal_instr(illegal_instr), .bus_error(bus_error)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  function automatic out_t get_out();
    out_t o;
    o = '{imem_req, ir_write, dmem_req, dmem_we, alu_ctrl, alu_src_imm, reg_write,
          result_src, base_write, link_write, pc_write, pc_src, flags, illegal_instr, bus_error};
    return o;
  endfunction

  function automatic out_t o_idle(input logic [3:0] f);
    out_t o;
    o = '0;
    o.flg = f;
    return o;
  endfunction

  function automatic out_t o_fetch(input logic [3:0] f);
    out_t o;
    o = o_idle(f);
    o.ireq = 1'b1;
    o.irw  = 1'b1;
    return o;
  endfunction

  task automatic drive(input in_t v);
    Cond = v.cond; Op = v.op; I = v.i; OpCode = v.opc; S = v.s; P = v.p; U = v.u;
    W = v.w; L1 = v.l1; L2 = v.l2; Rd = v.rd; alu_nzcv = v.nzcv;
    imem_ack = v.iack; dmem_ack = v.dack;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  in_t   tin[21];
  out_t  texp[21];
  string tnm[21];

  task automatic row(input int k, input string nm, input in_t a, input out_t b);
    tin[k] = a; texp[k] = b; tnm[k] = nm;
  endtask

  initial begin
    in_t add_i, cmp_i, beq_i, ne_i, ill_i, str_i, mov_i, ldr_i;
    out_t e;
    int cnt;

    //       cond   op     i     opc      s     p     u     w     l1    l2    rd     nzcv     iack  dack
    add_i = '{4'hE, 2'b00, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  4'b1001, 1'b1, 1'b1};
    cmp_i = '{4'hE, 2'b00, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'b0100, 1'b1, 1'b1};
    beq_i = '{4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'b0000, 1'b1, 1'b1};
    ne_i  = '{4'h1, 2'b00, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  4'b1111, 1'b1, 1'b1};
    ill_i = '{4'hE, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'b1111, 1'b1, 1'b1};
    str_i = '{4'hE, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  4'b1111, 1'b1, 1'b1};
    mov_i = '{4'hE, 2'b00, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'b1111, 1'b1, 1'b1};
    ldr_i = '{4'hE, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  4'b1111, 1'b1, 1'b0};

    // ADD S=1: flags take 1001 after EXEC
    row(0, "add_fetch", add_i, o_fetch(4'h0));
    row(1, "add_decode", add_i, o_idle(4'h0));
    e = o_idle(4'h0); e.alu = 4'b0100; e.imm = 1; e.rw = 1; e.pcw = 1;
    row(2, "add_exec", add_i, e);
    // CMP: no write, flags <= 0100
    row(3, "cmp_fetch", cmp_i, o_fetch(4'h9));
    row(4, "cmp_decode", cmp_i, o_idle(4'h9));
    e = o_idle(4'h9); e.alu = 4'b1010; e.pcw = 1;
    row(5, "cmp_exec", cmp_i, e);
    // BEQ with Z=1 and link
    row(6, "beq_fetch", beq_i, o_fetch(4'h4));
    row(7, "beq_decode", beq_i, o_idle(4'h4));
    e = o_idle(4'h4); e.pcw = 1; e.pcs = 2'b01; e.lw = 1;
    row(8, "beq_branch", beq_i, e);
    // NE with Z=1 fails in DECODE
    row(9, "ne_fetch", ne_i, o_fetch(4'h4));
    e = o_idle(4'h4); e.pcw = 1;
    row(10, "ne_skip", ne_i, e);
    // Illegal class
    row(11, "ill_fetch", ill_i, o_fetch(4'h4));
    e = o_idle(4'h4); e.pcw = 1; e.ill = 1;
    row(12, "ill_decode", ill_i, e);
    // STR pre-index up, no writeback, immediate ack
    row(13, "str_fetch", str_i, o_fetch(4'h4));
    row(14, "str_decode", str_i, o_idle(4'h4));
    e = o_idle(4'h4); e.alu = 4'b0100; e.imm = 1;
    row(15, "str_addr", str_i, e);
    e = o_idle(4'h4); e.dreq = 1; e.dwe = 1; e.pcw = 1;
    row(16, "str_mem", str_i, e);
    // MOV to PC, S=0: flags unchanged
    row(17, "mov_fetch", mov_i, o_fetch(4'h4));
    row(18, "mov_decode", mov_i, o_idle(4'h4));
    e = o_idle(4'h4); e.alu = 4'b1101; e.rw = 1; e.pcw = 1; e.pcs = 2'b10;
    row(19, "mov_exec", mov_i, e);
    row(20, "next_fetch", add_i, o_fetch(4'h4));

    // Reset state
    repeat (2) @(negedge clk);
    drive(add_i);
    #1;
    chk("reset_outputs", 32'(get_out()), 32'(o_idle(4'h0)));
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      drive(tin[k]);
      #1;
      chk(tnm[k], 32'(get_out()), 32'(texp[k]));
`ifdef CTRL_PERF_CNT_EN
      if (k == 20) chk("retired_cnt", retired_cnt, 32'd5);
`endif
      @(negedge clk);
    end

    // LDR post-index down, dmem_ack on the 4th MEM_RD cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(ldr_i);
    #1;
    chk("ldr_fetch_irw", {31'd0, ir_write}, 32'd1);
    @(negedge clk);
    #1;
    chk("ldr_decode", 32'(get_out()), 32'(o_idle(4'h0)));
    @(negedge clk);
    #1;
    e = o_idle(4'h0); e.alu = 4'b0010; e.bw = 1;
    chk("ldr_addr", 32'(get_out()), 32'(e));
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_ack = (k == 3);
      #1;
      if (dmem_req && !dmem_we && !pc_write) cnt++;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    chk("ldr_req_cycles", cnt, 32'd4);
    #1;
    e = o_idle(4'h0); e.rw = 1; e.rsrc = 1; e.pcw = 1;
    chk("ldr_wb", 32'(get_out()), 32'(e));
    @(negedge clk);

    // Fetch timeout: imem_ack never arrives
    imem_ack = 1'b0;
    #1;
    cnt = 0;
    for (int k = 0; k < TIMEOUT + 100; k++) begin
      if (!imem_req) break;
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("timeout_req_cycles", cnt, TIMEOUT);
    chk("timeout_bus_error", {31'd0, bus_error}, 32'd1);
    e = o_idle(4'h0); e.be = 1;
    chk("halt_outputs", 32'(get_out()), 32'(e));
    imem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("halt_ignores_ack", 32'(get_out()), 32'(e));

    // Reset in the middle of MEM_RD
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(ldr_i);
    repeat (3) @(negedge clk);
    #1;
    chk("memrd_req_before_rst", {31'd0, dmem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_memrd", 32'(get_out()), 32'(o_idle(4'h0)));
`ifdef CTRL_PERF_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(add_i);
    #1;
    chk("fetch_after_rst", 32'(get_out()), 32'(o_fetch(4'h0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
